uart_tx_arb: RTL
================

Name: uart_tx_arb

Overview:
Round-robin arbiter and sequencer that shares one uart_tx serializer among N_REQ byte-stream requesters.
- Grants are packet-locked: the granted requester keeps the serializer until it sends a byte flagged last.
- Also generates the one-cycle baud pulse (o_txpulse) that drives the serializer's i_txpulse.
- Sits between the system-side byte producers (debug console, status reporter, ...) and the single uart_tx instance.

Parameters:
N_REQ, 4, number of requesters (2..8)
CLKS_PER_BIT, 434, i_clk cycles per UART bit (50 MHz / 115200)
TIMEOUT_CYCLES, 65535, idle cycles before a locked grant is revoked (only with UART_ARB_TIMEOUT_EN)

Ports:
i_clk  input  1  system clock
w_intrst  input  1  reset w_intrst, asynchronous, active-high; clock i_clk
i_req_data  input  8*N_REQ  byte per requester; requester k in bits [8k+7:8k]
i_req_valid  input  N_REQ  per-requester byte valid
i_req_last  input  N_REQ  per-requester end-of-packet flag, qualified by valid
o_req_ready  output  N_REQ  per-requester ready; at most one bit high
o_grant  output  N_REQ  one-hot current grant; 0 when no grant is held
o_tx_data  output  8  byte to uart_tx i_data
o_tx_valid  output  1  to uart_tx i_valid
i_tx_ready  input  1  from uart_tx o_ready
o_txpulse  output  1  baud strobe to uart_tx i_txpulse
o_busy  output  1  high whenever state != S_ARB

Behaviour:
Reset values:
- o_tx_valid=0, o_tx_data=0, o_grant=0, o_req_ready=0, o_txpulse=0, o_busy=0.
- state=S_ARB; r_ptr=N_REQ-1, so requester 0 has first priority; baud counter=0.

Handshakes:
- A transfer occurs on any cycle where valid&&ready, on both the requester side and the tx side.
- Requesters hold data, valid and last stable until ready.

State S_ARB:
- Scan requesters r_ptr+1 .. r_ptr+N_REQ (mod N_REQ) and grant the first with i_req_valid set.
- On a grant: register o_grant one-hot, set r_ptr=granted index, go to S_FETCH.
- If no requester is valid, stay in S_ARB.

State S_FETCH:
- o_req_ready[grant]=1, driven combinationally from state and grant.
- On a transfer: o_tx_data<=byte, o_tx_valid<=1, r_last<=i_req_last[grant], go to S_SEND.

State S_SEND:
- o_req_ready=0.
- When o_tx_valid&&i_tx_ready: o_tx_valid<=0.
  - If r_last: o_grant<=0, go to S_ARB.
  - Otherwise: go to S_FETCH.

Latency and throughput:
- Request valid in S_ARB to o_tx_valid high: 2 cycles.
- Byte-to-byte throughput is limited by uart_tx, at 10 bit-times per byte.

Fairness:
- The pointer updates only on a grant.
- A requester that just completed a packet has lowest priority in the next arbitration.

Baud generator:
- Free-running counter over 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT).
- o_txpulse is high for exactly one cycle when the count is CLKS_PER_BIT-1, then the count wraps to 0.
- Independent of the state machine.

Boundary conditions:
- Granted requester drops valid mid-packet: the grant is held (stay in S_FETCH); other requesters stall.
- Non-granted requester asserts i_req_last: ignored.
- Single-byte packet (last on the first byte): returns to S_ARB after that one tx handshake.
- Simultaneous requests from all N_REQ: served strictly in rotation order.
- Reset mid-packet: all state cleared; any byte held in o_tx_data is dropped. uart_tx shares w_intrst.

Optional Feature:
UART_ARB_TIMEOUT_EN
- Defined:
  - A 16-bit idle counter runs in S_FETCH, incrementing while i_req_valid[grant]=0 and clearing on valid.
  - On reaching TIMEOUT_CYCLES: o_grant<=0, go to S_ARB; r_ptr is kept, so the timed-out requester gets lowest priority.
  - Also adds output o_timeout (1 bit), a one-cycle pulse when the grant is revoked. Reset value 0.
- Not defined: the grant is held indefinitely, and neither the counter nor o_timeout exists.

Decomposition:
- Shared package uart_pkg:
  - state encodings S_ARB=0, S_FETCH=1, S_SEND=2 (2-bit);
  - default CLKS_PER_BIT and TIMEOUT_CYCLES constants.
- Sub-module uart_baud_gen:
  - parameter CLKS_PER_BIT; ports i_clk, w_intrst, o_txpulse;
  - instantiated once inside uart_tx_arb.

Test Plan:
- Single requester 0 sends 0x55 (last=1), with uart_tx attached and CLKS_PER_BIT=4 -> o_tx_valid rises 2 cycles after valid; serial line shows start, the data bits, stop; o_grant returns to 0.
- Requesters 1 and 2 each assert a 2-byte packet in the same cycle (0xA1,0xA2 and 0xB1,0xB2) -> requester 1 served first, output order A1,A2,B1,B2; no interleaving.
- All 4 requesters continuously valid with 1-byte packets -> grant order 0,1,2,3,0,1...; o_req_ready is always one-hot or zero.
- Requester 3 sends 0x10 (last=0), then drops valid for 200 cycles, then sends 0x11 (last=1) -> requesters 0..2 are blocked throughout; output 0x10,0x11 (timeout macro off).
- With UART_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=50, same stimulus plus requester 0 valid -> o_timeout pulses 50 cycles after 0x10 is accepted; requester 0 is granted next.
- Assert w_intrst while in S_SEND -> all outputs are at reset values in the same cycle; after release the first pending requester 0 is granted within 1 cycle; o_txpulse resumes period 4.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-side blocks.
//   state_t            : arbiter sequencer states (2-bit encoding)
//   CLKS_PER_BIT_DEF   : default i_clk cycles per UART bit (50 MHz / 115200)
//   TIMEOUT_CYCLES_DEF : default idle cycles before a locked grant is revoked
package uart_pkg;

  typedef enum logic [1:0] {
    S_ARB   = 2'd0,
    S_FETCH = 2'd1,
    S_SEND  = 2'd2
  } state_t;

  localparam int CLKS_PER_BIT_DEF   = 434;
  localparam int TIMEOUT_CYCLES_DEF = 65535;

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running baud strobe generator.
//   i_clk     : system clock
//   w_intrst  : asynchronous active-high reset, clears the counter
//   o_txpulse : one-cycle strobe every CLKS_PER_BIT cycles (count == CLKS_PER_BIT-1)
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic i_clk,
  input  logic w_intrst,
  output logic o_txpulse
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge w_intrst) begin
    if (w_intrst) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_MAX) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Decoded from the count so the strobe is low while reset holds the count at 0.
  assign o_txpulse = (r_cnt == CNT_MAX);

endmodule

// File: rtl/uart_tx_arb.sv
// Packet-locked round-robin arbiter sharing one uart_tx among N_REQ requesters.
//   i_clk, w_intrst : clock, asynchronous active-high reset
//   i_req_data      : requester k byte in bits [8k+7:8k]
//   i_req_valid     : per-requester byte valid
//   i_req_last      : per-requester end-of-packet flag (qualified by valid)
//   o_req_ready     : ready to the granted requester while fetching (at most one bit)
//   o_grant         : one-hot grant, 0 when no grant is held
//   o_tx_data/valid : byte handshake toward uart_tx, i_tx_ready is its ready
//   o_txpulse       : baud strobe for uart_tx
//   o_busy          : high whenever the sequencer is not arbitrating
// Optional build macro UART_ARB_TIMEOUT_EN adds an idle watchdog on the locked
// grant and the o_timeout pulse output.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int CLKS_PER_BIT   = CLKS_PER_BIT_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic               i_clk,
  input  logic               w_intrst,
  input  logic [8*N_REQ-1:0] i_req_data,
  input  logic [N_REQ-1:0]   i_req_valid,
  input  logic [N_REQ-1:0]   i_req_last,
  output logic [N_REQ-1:0]   o_req_ready,
  output logic [N_REQ-1:0]   o_grant,
  output logic [7:0]         o_tx_data,
  output logic               o_tx_valid,
  input  logic               i_tx_ready,
  output logic               o_txpulse,
  output logic               o_busy
`ifdef UART_ARB_TIMEOUT_EN
  ,
  output logic               o_timeout
`endif
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam logic [N_REQ-1:0] GRANT_LSB = N_REQ'(1);

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
    $error("uart_tx_arb: N_REQ must be 2..8 and TIMEOUT_CYCLES 1..65535");
  end

  state_t             r_state;
  state_t             w_state_nxt;
  logic [PTR_W-1:0]   r_ptr;
  logic               r_last;
  logic               w_pick_vld;
  logic [PTR_W-1:0]   w_pick_idx;
  logic [PTR_W-1:0]   w_cand;
  logic [7:0]         w_sel_data;
  logic               w_sel_valid;
  logic               w_sel_last;
  logic               w_fetch_hs;
  logic               w_send_hs;
  logic               w_timeout;

  function automatic logic [PTR_W-1:0] rr_idx(input logic [PTR_W-1:0] base, input int ofs);
    return PTR_W'((int'(base) + ofs) % N_REQ);
  endfunction

  uart_baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_gen (
    .i_clk     (i_clk),
    .w_intrst  (w_intrst),
    .o_txpulse (o_txpulse)
  );

  // Rotating scan starting just past the last granted index, so the requester
  // that held the line most recently is considered last.
  always_comb begin
    w_pick_vld = 1'b0;
    w_pick_idx = r_ptr;
    w_cand     = r_ptr;
    for (int i = 1; i <= N_REQ; i++) begin
      w_cand = rr_idx(r_ptr, i);
      if (!w_pick_vld && i_req_valid[w_cand]) begin
        w_pick_vld = 1'b1;
        w_pick_idx = w_cand;
      end
    end
  end

  // r_ptr only moves on a grant, so while a grant is held it names the owner.
  always_comb begin
    w_sel_data  = '0;
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (r_ptr == PTR_W'(k)) begin
        w_sel_data  = i_req_data[8*k +: 8];
        w_sel_valid = i_req_valid[k];
        w_sel_last  = i_req_last[k];
      end
    end
  end

  always_comb begin
    o_req_ready = (r_state == S_FETCH) ? o_grant : '0;
  end

  assign w_fetch_hs = (r_state == S_FETCH) && w_sel_valid;
  assign w_send_hs  = (r_state == S_SEND) && o_tx_valid && i_tx_ready;
  assign o_busy     = (r_state != S_ARB);

`ifdef UART_ARB_TIMEOUT_EN
  logic [15:0] r_idle_cnt;

  // Counts consecutive fetch cycles with the owner idle; the revoke fires on
  // the TIMEOUT_CYCLES-th such cycle.
  assign w_timeout = (r_state == S_FETCH) && !w_sel_valid &&
                     (r_idle_cnt == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk or posedge w_intrst) begin
    if (w_intrst) begin
      r_idle_cnt <= '0;
      o_timeout  <= 1'b0;
    end else begin
      o_timeout <= w_timeout;
      if (r_state != S_FETCH || w_sel_valid || w_timeout) begin
        r_idle_cnt <= '0;
      end else begin
        r_idle_cnt <= r_idle_cnt + 16'd1;
      end
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge w_intrst) begin
    if (w_intrst) begin
      r_state <= S_ARB;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_ARB: begin
        if (w_pick_vld) begin
          w_state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        if (w_fetch_hs) begin
          w_state_nxt = S_SEND;
        end else if (w_timeout) begin
          w_state_nxt = S_ARB;
        end
      end
      S_SEND: begin
        if (w_send_hs) begin
          w_state_nxt = r_last ? S_ARB : S_FETCH;
        end
      end
      default: w_state_nxt = S_ARB;
    endcase
  end

  always_ff @(posedge i_clk or posedge w_intrst) begin
    if (w_intrst) begin
      r_ptr      <= PTR_W'(N_REQ - 1);
      o_grant    <= '0;
      o_tx_data  <= '0;
      o_tx_valid <= 1'b0;
      r_last     <= 1'b0;
    end else begin
      if (r_state == S_ARB && w_pick_vld) begin
        o_grant <= GRANT_LSB << w_pick_idx;
        r_ptr   <= w_pick_idx;
      end
      if (w_fetch_hs) begin
        o_tx_data  <= w_sel_data;
        o_tx_valid <= 1'b1;
        r_last     <= w_sel_last;
      end
      if (w_send_hs) begin
        o_tx_valid <= 1'b0;
        if (r_last) begin
          o_grant <= '0;
        end
      end
      if (w_timeout) begin
        o_grant <= '0;
      end
    end
  end

endmodule
